// File: rtl/arith_dispatcher_pkg.sv
// Shared constants, FSM state and hold-entry layout for the arithmetic dispatcher.
package arith_dispatcher_pkg;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int OPENUM_W = 6;
  localparam int REG_W    = 5;

  localparam logic [ROB_ID_W-1:0] ZERO_ROB   = '0;
  localparam logic [OPENUM_W-1:0] OPENUM_NOP = '0;
  localparam logic                TRUE       = 1'b1;
  localparam logic                FALSE      = 1'b0;

  typedef enum logic {EMPTY, HOLD} state_t;

  typedef struct packed {
    logic [OPENUM_W-1:0] openum;
    logic [REG_W-1:0]    rd;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   imm;
  } hold_t;

  function automatic logic cdb_hit(input logic valid, input logic [ROB_ID_W-1:0] id,
                                   input logic [ROB_ID_W-1:0] q);
    return valid && (q != ZERO_ROB) && (id == q);
  endfunction
endpackage

// File: rtl/arith_dispatcher_if.sv
// Decoder, regfile, ROB, CDB and RS signals seen by the arithmetic dispatcher.
interface arith_dispatcher_if;
  import arith_dispatcher_pkg::*;

  logic                dec_valid, dec_ready;
  logic [OPENUM_W-1:0] dec_openum;
  logic [REG_W-1:0]    dec_rd, dec_rs1, dec_rs2;
  logic                dec_use_rs1, dec_use_rs2;
  logic [DATA_W-1:0]   dec_imm, dec_pc;
  logic [REG_W-1:0]    rf_rs1_idx, rf_rs2_idx;
  logic [ROB_ID_W-1:0] rf_q1, rf_q2;
  logic [DATA_W-1:0]   rf_v1, rf_v2;
  logic [ROB_ID_W-1:0] rob_q1_idx, rob_q2_idx;
  logic                rob_q1_ready, rob_q2_ready;
  logic [DATA_W-1:0]   rob_q1_value, rob_q2_value;
  logic                rob_full;
  logic [ROB_ID_W-1:0] rob_free_id;
  logic                rob_alloc_en;
  logic [REG_W-1:0]    rob_alloc_rd;
  logic [DATA_W-1:0]   rob_alloc_pc;
  logic                rf_rename_en;
  logic [REG_W-1:0]    rf_rename_rd;
  logic [ROB_ID_W-1:0] rf_rename_id;
  logic                cdb_a_valid, cdb_ls_valid;
  logic [ROB_ID_W-1:0] cdb_a_id, cdb_ls_id;
  logic [DATA_W-1:0]   cdb_a_value, cdb_ls_value;
  logic                rs_full, rs_enable;
  logic [OPENUM_W-1:0] rs_openum;
  logic [ROB_ID_W-1:0] rs_q1, rs_q2, rs_rob_id;
  logic [DATA_W-1:0]   rs_v1, rs_v2, rs_pc, rs_imm;

  modport master (
    input  dec_valid, dec_openum, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_imm, dec_pc, rf_q1, rf_q2, rf_v1, rf_v2, rob_q1_ready, rob_q2_ready,
           rob_q1_value, rob_q2_value, rob_full, rob_free_id, cdb_a_valid, cdb_ls_valid,
           cdb_a_id, cdb_ls_id, cdb_a_value, cdb_ls_value, rs_full,
    output dec_ready, rf_rs1_idx, rf_rs2_idx, rob_q1_idx, rob_q2_idx, rob_alloc_en,
           rob_alloc_rd, rob_alloc_pc, rf_rename_en, rf_rename_rd, rf_rename_id,
           rs_enable, rs_openum, rs_q1, rs_q2, rs_v1, rs_v2, rs_pc, rs_imm, rs_rob_id
  );

  modport slave (
    output dec_valid, dec_openum, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_imm, dec_pc, rf_q1, rf_q2, rf_v1, rf_v2, rob_q1_ready, rob_q2_ready,
           rob_q1_value, rob_q2_value, rob_full, rob_free_id, cdb_a_valid, cdb_ls_valid,
           cdb_a_id, cdb_ls_id, cdb_a_value, cdb_ls_value, rs_full,
    input  dec_ready, rf_rs1_idx, rf_rs2_idx, rob_q1_idx, rob_q2_idx, rob_alloc_en,
           rob_alloc_rd, rob_alloc_pc, rf_rename_en, rf_rename_rd, rf_rename_id,
           rs_enable, rs_openum, rs_q1, rs_q2, rs_v1, rs_v2, rs_pc, rs_imm, rs_rob_id
  );
endinterface

// File: rtl/arith_dispatcher_operand_resolver.sv
// Resolves one operand to a (tag, value) pair: regfile, then CDBs, then ROB, else keep tag.
module arith_dispatcher_operand_resolver
  import arith_dispatcher_pkg::*;
(
  input  logic                i_use,
  input  logic [ROB_ID_W-1:0] i_rf_q,
  input  logic [DATA_W-1:0]   i_rf_v,
  input  logic                i_cdb_a_valid,
  input  logic [ROB_ID_W-1:0] i_cdb_a_id,
  input  logic [DATA_W-1:0]   i_cdb_a_value,
  input  logic                i_cdb_ls_valid,
  input  logic [ROB_ID_W-1:0] i_cdb_ls_id,
  input  logic [DATA_W-1:0]   i_cdb_ls_value,
  input  logic                i_rob_ready,
  input  logic [DATA_W-1:0]   i_rob_value,
  output logic [ROB_ID_W-1:0] o_q,
  output logic [DATA_W-1:0]   o_v
);
  // NOTE: both outputs get a default before any branch so no latch can be inferred.
  always_comb begin
    o_q = i_rf_q;
    o_v = '0;
    if (!i_use) begin
      o_q = ZERO_ROB;
    end else if (i_rf_q == ZERO_ROB) begin
      o_v = i_rf_v;
    end else if (cdb_hit(i_cdb_a_valid, i_cdb_a_id, i_rf_q)) begin
      o_q = ZERO_ROB;
      o_v = i_cdb_a_value;
    end else if (cdb_hit(i_cdb_ls_valid, i_cdb_ls_id, i_rf_q)) begin
      o_q = ZERO_ROB;
      o_v = i_cdb_ls_value;
    end else if (i_rob_ready) begin
      o_q = ZERO_ROB;
      o_v = i_rob_value;
    end
  end
endmodule

// File: rtl/arith_dispatcher.sv
// One-entry hold register between the decoder and the arithmetic RS; resolves operands,
// allocates the ROB id and renames rd on dispatch.
module arith_dispatcher
  import arith_dispatcher_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               misbranch_flag,
  arith_dispatcher_if.master bus
);
  state_t              r_state, w_state_nxt;
  hold_t               r_hold, r_rs;
  logic [ROB_ID_W-1:0] r_rob_id;
  logic                r_rs_enable, r_rename_en;
  logic                w_capture, w_dispatch, w_holding;
  logic [ROB_ID_W-1:0] w_q1, w_q2;
  logic [DATA_W-1:0]   w_v1, w_v2;

  assign w_holding = (r_state == HOLD);

  // In HOLD the resolvers re-snoop the held tags; otherwise they resolve the decoder's operands.
  arith_dispatcher_operand_resolver u_res1 (
    .i_use(w_holding || bus.dec_use_rs1),
    .i_rf_q(w_holding ? r_hold.q1 : bus.rf_q1), .i_rf_v(w_holding ? r_hold.v1 : bus.rf_v1),
    .i_cdb_a_valid(bus.cdb_a_valid), .i_cdb_a_id(bus.cdb_a_id), .i_cdb_a_value(bus.cdb_a_value),
    .i_cdb_ls_valid(bus.cdb_ls_valid), .i_cdb_ls_id(bus.cdb_ls_id),
    .i_cdb_ls_value(bus.cdb_ls_value),
    .i_rob_ready(bus.rob_q1_ready), .i_rob_value(bus.rob_q1_value), .o_q(w_q1), .o_v(w_v1)
  );

  arith_dispatcher_operand_resolver u_res2 (
    .i_use(w_holding || bus.dec_use_rs2),
    .i_rf_q(w_holding ? r_hold.q2 : bus.rf_q2), .i_rf_v(w_holding ? r_hold.v2 : bus.rf_v2),
    .i_cdb_a_valid(bus.cdb_a_valid), .i_cdb_a_id(bus.cdb_a_id), .i_cdb_a_value(bus.cdb_a_value),
    .i_cdb_ls_valid(bus.cdb_ls_valid), .i_cdb_ls_id(bus.cdb_ls_id),
    .i_cdb_ls_value(bus.cdb_ls_value),
    .i_rob_ready(bus.rob_q2_ready), .i_rob_value(bus.rob_q2_value), .o_q(w_q2), .o_v(w_v2)
  );

  assign bus.rf_rs1_idx = bus.dec_rs1;
  assign bus.rf_rs2_idx = bus.dec_rs2;
  assign bus.rob_q1_idx = w_holding ? r_hold.q1 : (bus.dec_use_rs1 ? bus.rf_q1 : ZERO_ROB);
  assign bus.rob_q2_idx = w_holding ? r_hold.q2 : (bus.dec_use_rs2 ? bus.rf_q2 : ZERO_ROB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= EMPTY;
    else if (rdy) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = FALSE;
    w_dispatch    = FALSE;
    bus.dec_ready = (r_state == EMPTY) && !misbranch_flag;
    if (misbranch_flag) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (bus.dec_valid) begin
          w_capture   = TRUE;
          w_state_nxt = HOLD;
        end
        // rs_full lags one RS write, so a pulse in flight blocks the next dispatch.
        HOLD: if (!bus.rs_full && !bus.rob_full && !r_rs_enable) begin
          w_dispatch  = TRUE;
          w_state_nxt = EMPTY;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_rs        <= '0;
      r_rob_id    <= ZERO_ROB;
      r_rs_enable <= FALSE;
      r_rename_en <= FALSE;
    end else if (rdy) begin
      r_rs_enable <= w_dispatch;
      r_rename_en <= w_dispatch && (r_hold.rd != '0);
      if (w_capture) begin
        r_hold <= '{openum: bus.dec_openum, rd: bus.dec_rd, q1: w_q1, q2: w_q2,
                    v1: w_v1, v2: w_v2, pc: bus.dec_pc, imm: bus.dec_imm};
      end else if (w_holding) begin
        r_hold.q1 <= w_q1;
        r_hold.v1 <= w_v1;
        r_hold.q2 <= w_q2;
        r_hold.v2 <= w_v2;
      end
      if (w_dispatch) begin
        r_rs <= '{openum: r_hold.openum, rd: r_hold.rd, q1: w_q1, q2: w_q2,
                  v1: w_v1, v2: w_v2, pc: r_hold.pc, imm: r_hold.imm};
        r_rob_id <= bus.rob_free_id;
      end
    end
  end

  assign bus.rs_enable    = r_rs_enable;
  assign bus.rob_alloc_en = r_rs_enable;
  assign bus.rob_alloc_rd = r_rs.rd;
  assign bus.rob_alloc_pc = r_rs.pc;
  assign bus.rf_rename_en = r_rename_en;
  assign bus.rf_rename_rd = r_rs.rd;
  assign bus.rf_rename_id = r_rob_id;
  assign bus.rs_openum    = r_rs.openum;
  assign bus.rs_q1        = r_rs.q1;
  assign bus.rs_q2        = r_rs.q2;
  assign bus.rs_v1        = r_rs.v1;
  assign bus.rs_v2        = r_rs.v2;
  assign bus.rs_pc        = r_rs.pc;
  assign bus.rs_imm       = r_rs.imm;
  assign bus.rs_rob_id    = r_rob_id;
endmodule

// File: tb/tb_arith_dispatcher.sv
// Directed-vector bench for arith_dispatcher with a small regfile-tag and ROB-ready model.
module tb_arith_dispatcher;
  import arith_dispatcher_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, misbranch_flag;
  arith_dispatcher_if bus ();

  arith_dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Regfile tag model: a rename pulse is visible to the following capture.
  logic [ROB_ID_W-1:0] rf_tag [32];
  logic [DATA_W-1:0]   rf_val [32];
  logic                rob_rdy_en;
  logic [ROB_ID_W-1:0] rob_rdy_tag;
  logic [DATA_W-1:0]   rob_rdy_val;

  always @(posedge clk)
    if (!rst && rdy && bus.rf_rename_en) rf_tag[bus.rf_rename_rd] <= bus.rf_rename_id;

  always_comb begin
    bus.rf_q1 = rf_tag[bus.rf_rs1_idx];
    bus.rf_q2 = rf_tag[bus.rf_rs2_idx];
    if (bus.rf_rename_en && bus.rf_rename_rd != '0) begin
      if (bus.rf_rename_rd == bus.rf_rs1_idx) bus.rf_q1 = bus.rf_rename_id;
      if (bus.rf_rename_rd == bus.rf_rs2_idx) bus.rf_q2 = bus.rf_rename_id;
    end
    bus.rf_v1        = rf_val[bus.rf_rs1_idx];
    bus.rf_v2        = rf_val[bus.rf_rs2_idx];
    bus.rob_q1_ready = rob_rdy_en && (bus.rob_q1_idx == rob_rdy_tag);
    bus.rob_q2_ready = rob_rdy_en && (bus.rob_q2_idx == rob_rdy_tag);
    bus.rob_q1_value = rob_rdy_val;
    bus.rob_q2_value = rob_rdy_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int op, input int rd, input int rs1, input int rs2,
                       input int u1, input int u2, input int imm, input int pc);
    bus.dec_valid   = 1'b1;
    bus.dec_openum  = OPENUM_W'(op);
    bus.dec_rd      = REG_W'(rd);
    bus.dec_rs1     = REG_W'(rs1);
    bus.dec_rs2     = REG_W'(rs2);
    bus.dec_use_rs1 = (u1 != 0);
    bus.dec_use_rs2 = (u2 != 0);
    bus.dec_imm     = DATA_W'(imm);
    bus.dec_pc      = DATA_W'(pc);
  endtask

  // Counts edges until rs_enable is seen; an expired budget is itself a miscompare.
  task automatic wait_enable(input int max, output int n);
    n = 0;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (bus.rs_enable) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("enable_timeout", 32'(bus.rs_enable), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, e1, e2;
    rst = 1'b1; rdy = 1'b1; misbranch_flag = 1'b0;
    bus.dec_valid = 1'b0; bus.dec_openum = '0; bus.dec_rd = '0; bus.dec_rs1 = '0;
    bus.dec_rs2 = '0; bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0;
    bus.dec_imm = '0; bus.dec_pc = '0; bus.rob_full = 1'b0; bus.rob_free_id = '0;
    bus.cdb_a_valid = 1'b0; bus.cdb_a_id = '0; bus.cdb_a_value = '0;
    bus.cdb_ls_valid = 1'b0; bus.cdb_ls_id = '0; bus.cdb_ls_value = '0; bus.rs_full = 1'b0;
    rob_rdy_en = 1'b0; rob_rdy_tag = '0; rob_rdy_val = '0;
    for (int i = 0; i < 32; i++) begin
      rf_tag[i] = '0;
      rf_val[i] = '0;
    end
    rf_val[1] = 5;
    rf_val[2] = 7;

    repeat (2) tick();
    check("rst_dec_ready", 32'(bus.dec_ready), 1);
    check("rst_rs_enable", 32'(bus.rs_enable), 0);
    check("rst_rs_openum", 32'(bus.rs_openum), 32'(OPENUM_NOP));
    check("rst_rs_rob_id", 32'(bus.rs_rob_id), 32'(ZERO_ROB));
    check("rst_rename_en", 32'(bus.rf_rename_en), 0);
    @(negedge clk) rst = 1'b0;

    // Independent op: both operands valid in the regfile.
    @(negedge clk);
    offer(1, 4, 1, 2, 1, 1, 'h10, 'h100);
    bus.rob_free_id = 3;
    tick();
    check("t1_dec_ready_hold", 32'(bus.dec_ready), 0);
    @(negedge clk) bus.dec_valid = 1'b0;
    wait_enable(6, n);
    check("t1_latency", n, 1);
    check("t1_q1", 32'(bus.rs_q1), 0);
    check("t1_q2", 32'(bus.rs_q2), 0);
    check("t1_v1", bus.rs_v1, 5);
    check("t1_v2", bus.rs_v2, 7);
    check("t1_rob_id", 32'(bus.rs_rob_id), 3);
    check("t1_openum", 32'(bus.rs_openum), 1);
    check("t1_pc", bus.rs_pc, 'h100);
    check("t1_imm", bus.rs_imm, 'h10);
    check("t1_alloc_en", 32'(bus.rob_alloc_en), 1);
    check("t1_alloc_rd", 32'(bus.rob_alloc_rd), 4);
    check("t1_rename_en", 32'(bus.rf_rename_en), 1);
    check("t1_rename_rd", 32'(bus.rf_rename_rd), 4);
    check("t1_rename_id", 32'(bus.rf_rename_id), 3);
    tick();
    check("t1_enable_drop", 32'(bus.rs_enable), 0);
    check("t1_rename_drop", 32'(bus.rf_rename_en), 0);
    check("t1_v1_held", bus.rs_v1, 5);

    // CDB-A hit on Q1 in the capture cycle; rd = 0 so no rename.
    @(negedge clk);
    rf_tag[5] = 6;
    offer(2, 0, 5, 2, 1, 1, 'h20, 'h200);
    bus.cdb_a_valid = 1'b1; bus.cdb_a_id = 6; bus.cdb_a_value = 'h55;
    bus.rob_free_id = 7;
    tick();
    @(negedge clk);
    bus.dec_valid = 1'b0; bus.cdb_a_valid = 1'b0;
    wait_enable(6, n);
    check("t2_latency", n, 1);
    check("t2_q1", 32'(bus.rs_q1), 0);
    check("t2_v1", bus.rs_v1, 'h55);
    check("t2_v2", bus.rs_v2, 7);
    check("t2_rob_id", 32'(bus.rs_rob_id), 7);
    check("t2_rename_en_rd0", 32'(bus.rf_rename_en), 0);
    check("t2_alloc_en", 32'(bus.rob_alloc_en), 1);

    // RS full while holding; CDB-LS wakes the held Q2 = 9.
    @(negedge clk);
    rf_tag[8] = 9;
    bus.rs_full = 1'b1;
    offer(3, 9, 0, 8, 0, 1, 'h30, 'h300);
    bus.rob_free_id = 8;
    tick();
    @(negedge clk) bus.dec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cdb_ls_valid = (i == 1); bus.cdb_ls_id = 9; bus.cdb_ls_value = 'hAA;
      tick();
      check("t3_no_enable", 32'(bus.rs_enable), 0);
      check("t3_dec_ready", 32'(bus.dec_ready), 0);
    end
    @(negedge clk);
    bus.rs_full = 1'b0; bus.cdb_ls_valid = 1'b0;
    wait_enable(6, n);
    check("t3_latency", n, 1);
    check("t3_q2", 32'(bus.rs_q2), 0);
    check("t3_v2", bus.rs_v2, 'hAA);
    check("t3_q1_unused", 32'(bus.rs_q1), 0);
    check("t3_v1_unused", bus.rs_v1, 0);
    check("t3_rob_id", 32'(bus.rs_rob_id), 8);

    // Back-to-back: second instruction reads the first one's rd.
    @(negedge clk);
    offer(4, 10, 1, 2, 1, 1, 'h40, 'h400);
    bus.rob_free_id = 12;
    tick();
    @(negedge clk) offer(5, 11, 10, 2, 1, 1, 'h50, 'h500);
    tick();
    e1 = cyc;
    check("t4_a_enable", 32'(bus.rs_enable), 1);
    check("t4_a_rob_id", 32'(bus.rs_rob_id), 12);
    check("t4_a_rename_rd", 32'(bus.rf_rename_rd), 10);
    @(negedge clk) bus.rob_free_id = 13;
    tick();
    check("t4_no_b2b", 32'(bus.rs_enable), 0);
    @(negedge clk) bus.dec_valid = 1'b0;
    wait_enable(6, n);
    e2 = cyc;
    check("t4_gap", e2 - e1, 2);
    check("t4_b_q1", 32'(bus.rs_q1), 12);
    check("t4_b_v1", bus.rs_v1, 0);
    check("t4_b_v2", bus.rs_v2, 7);
    check("t4_b_rob_id", 32'(bus.rs_rob_id), 13);

    // Misbranch while holding discards the entry.
    @(negedge clk);
    offer(6, 12, 1, 2, 1, 1, 'h60, 'h600);
    bus.rob_free_id = 1;
    tick();
    @(negedge clk);
    bus.dec_valid = 1'b0; misbranch_flag = 1'b1;
    tick();
    check("t5_no_enable", 32'(bus.rs_enable), 0);
    check("t5_no_alloc", 32'(bus.rob_alloc_en), 0);
    @(negedge clk) misbranch_flag = 1'b0;
    #1;
    check("t5_dec_ready", 32'(bus.dec_ready), 1);
    tick();
    check("t5_still_idle", 32'(bus.rs_enable), 0);

    // ROB ready path at capture, then rdy low freezes the pulses.
    @(negedge clk);
    rf_tag[20] = 15;
    rob_rdy_en = 1'b1; rob_rdy_tag = 15; rob_rdy_val = 'h1234;
    offer(7, 13, 20, 2, 1, 1, 'h70, 'h700);
    bus.rob_free_id = 14;
    tick();
    @(negedge clk);
    bus.dec_valid = 1'b0; rob_rdy_en = 1'b0;
    wait_enable(6, n);
    check("t6_q1", 32'(bus.rs_q1), 0);
    check("t6_v1", bus.rs_v1, 'h1234);
    @(negedge clk) rdy = 1'b0;
    repeat (2) tick();
    check("t6_frozen_enable", 32'(bus.rs_enable), 1);
    check("t6_frozen_rename", 32'(bus.rf_rename_en), 1);
    @(negedge clk) rdy = 1'b1;
    tick();
    check("t6_enable_drop", 32'(bus.rs_enable), 0);

    // Asynchronous reset in the middle of HOLD.
    @(negedge clk);
    offer(8, 14, 1, 2, 1, 1, 'h80, 'h800);
    bus.rob_free_id = 2;
    tick();
    check("t7_holding", 32'(bus.dec_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_dec_ready", 32'(bus.dec_ready), 1);
    check("t7_rst_rob_id", 32'(bus.rs_rob_id), 0);
    check("t7_rst_v1", bus.rs_v1, 0);
    check("t7_rst_openum", 32'(bus.rs_openum), 0);
    @(negedge clk);
    rst = 1'b0; bus.dec_valid = 1'b0;
    tick();
    check("t7_discarded", 32'(bus.rs_enable), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
